// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the unified-memory port arbiter: arbiter state
//   encodings, the full-word byte-enable constant used for instruction fetch,
//   and a helper that sizes the wait-cycle timer.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_e;

  // Both byte lanes enabled; instruction fetch always reads a full word.
  localparam logic [1:0] BE_WORD = 2'b11;

  // Width of a counter that must be able to hold max_count.
  function automatic int tmr_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares a single-port unified memory between instruction fetch (IF) and the
//   load/store path (data). Data has fixed priority because it belongs to the
//   older instruction. The granted command is registered onto mem_* and held
//   until mem_ready; read data is returned with a one-cycle done pulse. A wait
//   timer forces an error completion if memory never answers.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   if_req/if_addr             fetch request (held until if_done) and address
//   if_rdata/if_done/if_stall  fetched word, completion pulse, stall
//   d_req/d_we/d_be/d_addr/d_wdata  data request, store flag, byte enables,
//                              address and store data
//   d_rdata/d_done/d_stall     load data (0 for stores), completion pulse, stall
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  registered memory command
//   mem_rdata/mem_ready        memory read data and accept/complete strobe
//   tmo_err                    sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TMO_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              tmo_err
);

  localparam int TMR_W = tmr_width(TMO_MAX);

  arb_state_e        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              tmo_err_q, tmo_err_d;

  logic if_req_m, d_req_m;
  logic busy, timeout, finish;
  logic grant_if, grant_d;

  // A requester whose done is pulsing this cycle still holds req; that stale
  // request must not start a second transaction.
  assign if_req_m = if_req & ~if_done_q;
  assign d_req_m  = d_req  & ~d_done_q;

  assign busy    = (state_q == ARB_FETCH) || (state_q == ARB_DATA);
  // The TMO_MAX-th consecutive cycle without mem_ready ends the transaction.
  assign timeout = busy && !mem_ready && ((int'(timer_q) + 1) >= TMO_MAX);
  assign finish  = busy && (mem_ready || timeout);

  // Arbitration: data first from IDLE; on completion only the other requester
  // can be granted, which gives back-to-back service without an IDLE bubble.
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        grant_d  = d_req_m;
        grant_if = ~d_req_m & if_req_m;
      end
      ARB_FETCH: grant_d  = finish & d_req_m;
      ARB_DATA:  grant_if = finish & if_req_m;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    tmo_err_d   = tmo_err_q;

    // Saturating wait counter; the command on mem_* is simply held.
    if (busy && !finish && (int'(timer_q) < TMO_MAX)) begin
      timer_d = timer_q + TMR_W'(1);
    end

    if (finish) begin
      if (timeout) begin
        tmo_err_d = 1'b1;
      end
      if (state_q == ARB_FETCH) begin
        if_done_d  = 1'b1;
        if_rdata_d = mem_ready ? mem_rdata : '0;
      end else begin
        d_done_d  = 1'b1;
        d_rdata_d = (mem_ready && !mem_we_q) ? mem_rdata : '0;
      end
      state_d   = ARB_IDLE;
      mem_req_d = 1'b0;
    end

    // Recover from an unused encoding.
    if (!busy && (state_q != ARB_IDLE)) begin
      state_d   = ARB_IDLE;
      mem_req_d = 1'b0;
    end

    // A grant in the completion cycle overrides the drop to IDLE.
    if (grant_d) begin
      state_d     = ARB_DATA;
      timer_d     = '0;
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_be_d    = d_be;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
    end else if (grant_if) begin
      state_d     = ARB_FETCH;
      timer_d     = '0;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_be_d    = BE_WORD;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      timer_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign tmo_err   = tmo_err_q;

  // Combinational from req and registered done only; no path from mem_ready.
  assign if_stall = if_req & ~if_done_q;
  assign d_stall  = d_req  & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed scenarios with literal expectations, then randomized requesters
//   and memory, all compared every cycle against a transaction-level model of
//   who owns the memory port, how long it has waited and what completes when.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_done, if_stall;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [1:0]    d_be = 2'b11;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_done, d_stall;
  logic          mem_req, mem_we;
  logic [1:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          tmo_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_MAX(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .tmo_err(tmo_err)
  );

  int checks = 0;
  int errors = 0;

  // Model: port owner (0 none, 1 fetch, 2 data), the command it was given,
  // cycles waited so far, and the completion visible this cycle.
  int            m_owner;
  int            m_wait;
  logic          m_we;
  logic [1:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_if_done, m_d_done;
  logic [DW-1:0] m_if_rdata, m_d_rdata;
  logic          m_tmo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_wait = 0; m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
    m_if_done = 0; m_d_done = 0; m_if_rdata = 0; m_d_rdata = 0; m_tmo = 0;
  endtask

  // One clock edge of the arbitration rules, using the inputs present now.
  task automatic model_edge();
    bit ifr, dr, fin, nif, nd;
    int nxt;
    ifr = if_req && !m_if_done;
    dr  = d_req && !m_d_done;
    fin = 0; nif = 0; nd = 0;
    nxt = m_owner;
    if (m_owner != 0) begin
      if (mem_ready || (m_wait + 1 >= TMO)) begin
        fin = 1;
        if (!mem_ready) m_tmo = 1;
        if (m_owner == 1) begin
          nif = 1;
          m_if_rdata = mem_ready ? mem_rdata : '0;
          nxt = dr ? 2 : 0;
        end else begin
          nd = 1;
          m_d_rdata = (mem_ready && !m_we) ? mem_rdata : '0;
          nxt = ifr ? 1 : 0;
        end
      end else begin
        m_wait++;
      end
    end else begin
      nxt = dr ? 2 : (ifr ? 1 : 0);
    end
    if ((m_owner == 0 || fin) && nxt == 2) begin
      m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata; m_wait = 0;
    end else if ((m_owner == 0 || fin) && nxt == 1) begin
      m_we = 0; m_be = 2'b11; m_addr = if_addr; m_wdata = 0; m_wait = 0;
    end
    m_owner   = nxt;
    m_if_done = nif;
    m_d_done  = nd;
  endtask

  task automatic check_all();
    chk("mem_req", 32'(mem_req), 32'(m_owner != 0));
    if (m_owner != 0) begin
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_be", 32'(mem_be), 32'(m_be));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (m_owner == 2 && m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    end
    chk("if_done", 32'(if_done), 32'(m_if_done));
    chk("d_done", 32'(d_done), 32'(m_d_done));
    if (m_if_done) chk("if_rdata", 32'(if_rdata), 32'(m_if_rdata));
    if (m_d_done) chk("d_rdata", 32'(d_rdata), 32'(m_d_rdata));
    chk("if_stall", 32'(if_stall), 32'(if_req && !m_if_done));
    chk("d_stall", 32'(d_stall), 32'(d_req && !m_d_done));
    chk("tmo_err", 32'(tmo_err), 32'(m_tmo));
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic go_idle();
    if_req = 0; d_req = 0; mem_ready = 0;
    repeat (3) cyc();
  endtask

  bit if_seen_done, d_seen_done;
  int rdy_level;

  initial begin
    model_reset();
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_if_done", 32'(if_done), 32'(0));
    chk("rst_d_done", 32'(d_done), 32'(0));
    chk("rst_tmo_err", 32'(tmo_err), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1;

    // Fetch, memory ready in the first cycle.
    if_req = 1; if_addr = 16'h0010;
    cyc();
    mem_ready = 1; mem_rdata = 16'hA5A5;
    settle();
    chk("f_mem_req", 32'(mem_req), 32'(1));
    chk("f_mem_addr", 32'(mem_addr), 32'h0010);
    chk("f_mem_be", 32'(mem_be), 32'(2'b11));
    advance();
    settle();
    chk("f_if_done", 32'(if_done), 32'(1));
    chk("f_if_rdata", 32'(if_rdata), 32'hA5A5);
    if_req = 0; mem_ready = 0;
    advance();
    go_idle();

    // Simultaneous requests: data first, then fetch with no IDLE gap.
    if_req = 1; if_addr = 16'h0200;
    d_req = 1; d_we = 0; d_be = 2'b11; d_addr = 16'h8000;
    cyc();
    mem_ready = 1; mem_rdata = 16'h1234;
    settle();
    chk("b_mem_addr_d", 32'(mem_addr), 32'h8000);
    chk("b_mem_we", 32'(mem_we), 32'(0));
    chk("b_if_stall1", 32'(if_stall), 32'(1));
    advance();
    mem_rdata = 16'h5678;
    settle();
    chk("b_d_done", 32'(d_done), 32'(1));
    chk("b_d_rdata", 32'(d_rdata), 32'h1234);
    chk("b_mem_req", 32'(mem_req), 32'(1));
    chk("b_mem_addr_f", 32'(mem_addr), 32'h0200);
    chk("b_if_stall2", 32'(if_stall), 32'(1));
    d_req = 0;
    advance();
    settle();
    chk("b_if_done", 32'(if_done), 32'(1));
    chk("b_if_rdata", 32'(if_rdata), 32'h5678);
    if_req = 0; mem_ready = 0;
    advance();
    go_idle();

    // Byte store with memory ready after three waiting cycles.
    d_req = 1; d_we = 1; d_be = 2'b10; d_addr = 16'h8001; d_wdata = 16'h3400;
    mem_rdata = 16'hFFFF;
    cyc();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      settle();
      chk("s_mem_we", 32'(mem_we), 32'(1));
      chk("s_mem_be", 32'(mem_be), 32'(2'b10));
      chk("s_mem_addr", 32'(mem_addr), 32'h8001);
      chk("s_mem_wdata", 32'(mem_wdata), 32'h3400);
      advance();
    end
    mem_ready = 0;
    settle();
    chk("s_d_done", 32'(d_done), 32'(1));
    chk("s_d_rdata", 32'(d_rdata), 32'(0));
    d_req = 0;
    advance();
    settle();
    chk("s_d_done_once", 32'(d_done), 32'(0));
    advance();
    go_idle();

    // Memory never answers: forced completion after TMO waiting cycles.
    d_req = 1; d_we = 0; d_be = 2'b11; d_addr = 16'h0100; mem_ready = 0;
    mem_rdata = 16'hBEEF;
    repeat (TMO + 1) cyc();
    settle();
    chk("t_d_done", 32'(d_done), 32'(1));
    chk("t_d_rdata", 32'(d_rdata), 32'(0));
    chk("t_tmo_err", 32'(tmo_err), 32'(1));
    d_req = 0;
    advance();
    go_idle();

    // Randomized traffic; tmo_err must stay set throughout.
    if_seen_done = 0; d_seen_done = 0;
    for (int c = 0; c < 3000; c++) begin
      if (if_seen_done) begin
        if_req = 1'($urandom_range(0, 1)); if_addr = 16'($urandom);
      end else if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin if_req = 1; if_addr = 16'($urandom); end
      end else if ($urandom_range(0, 31) == 0) begin
        if_req = 0;
      end
      if (d_seen_done || !d_req) begin
        if (d_seen_done || $urandom_range(0, 2) == 0) begin
          d_req = d_seen_done ? 1'($urandom_range(0, 1)) : 1'b1;
          d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
          case ($urandom_range(0, 2))
            0: d_be = 2'b11;
            1: d_be = 2'b01;
            default: d_be = 2'b10;
          endcase
        end
      end else if ($urandom_range(0, 31) == 0) begin
        d_req = 0;
      end
      rdy_level = (c < 1000) ? 4 : ((c < 2000) ? 1 : 7);
      mem_ready = ($urandom_range(0, 7) < rdy_level);
      mem_rdata = 16'($urandom);
      settle();
      if_seen_done = m_if_done;
      d_seen_done  = m_d_done;
      advance();
    end
    go_idle();

    // Asynchronous reset in the middle of a data transaction.
    d_req = 1; d_we = 0; d_be = 2'b11; d_addr = 16'h4444; mem_ready = 0;
    cyc();
    settle();
    chk("r_pre_req", 32'(mem_req), 32'(1));
    #2;
    rst_n = 0; d_req = 0;
    #1;
    chk("r_async_req", 32'(mem_req), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    chk("r_no_done", 32'(d_done), 32'(0));
    chk("r_tmo_clr", 32'(tmo_err), 32'(0));
    chk("r_req_low", 32'(mem_req), 32'(0));
    rst_n = 1;
    cyc();
    if_req = 1; if_addr = 16'h0042;
    cyc();
    mem_ready = 1; mem_rdata = 16'h0F0F;
    settle();
    chk("r_fetch_addr", 32'(mem_addr), 32'h0042);
    advance();
    settle();
    chk("r_fetch_done", 32'(if_done), 32'(1));
    if_req = 0; mem_ready = 0;
    advance();
    go_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
